// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control / multiply-divide slice: aluop codes,
// R-type funct values, aluctl codes and the MDU state type.
package alu_pkg;

  typedef enum logic [2:0] {
    AOP_ADD   = 3'b000,
    AOP_SUB   = 3'b001,
    AOP_RTYPE = 3'b010,
    AOP_AND   = 3'b011,
    AOP_OR    = 3'b100,
    AOP_SLT   = 3'b101,
    AOP_XOR   = 3'b110,
    AOP_LUI   = 3'b111
  } aluop_t;

  localparam int unsigned F_MFHI  = 16;
  localparam int unsigned F_MTHI  = 17;
  localparam int unsigned F_MFLO  = 18;
  localparam int unsigned F_MTLO  = 19;
  localparam int unsigned F_MULT  = 24;
  localparam int unsigned F_MULTU = 25;
  localparam int unsigned F_DIV   = 26;
  localparam int unsigned F_DIVU  = 27;
  localparam int unsigned F_ADD   = 32;
  localparam int unsigned F_ADDU  = 33;
  localparam int unsigned F_SUB   = 34;
  localparam int unsigned F_SUBU  = 35;
  localparam int unsigned F_AND   = 36;
  localparam int unsigned F_OR    = 37;
  localparam int unsigned F_XOR   = 38;
  localparam int unsigned F_NOR   = 39;
  localparam int unsigned F_SLT   = 42;
  localparam int unsigned F_SLTU  = 43;

  localparam logic [3:0] AC_AND  = 4'b0000;
  localparam logic [3:0] AC_OR   = 4'b0001;
  localparam logic [3:0] AC_ADD  = 4'b0010;
  localparam logic [3:0] AC_XOR  = 4'b0011;
  localparam logic [3:0] AC_SUB  = 4'b0110;
  localparam logic [3:0] AC_SLT  = 4'b0111;
  localparam logic [3:0] AC_SLTU = 4'b1000;
  localparam logic [3:0] AC_NOR  = 4'b1100;
  localparam logic [3:0] AC_LUI  = 4'b1101;
  localparam logic [3:0] AC_BAD  = 4'b1111;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_SIGN
  } md_state_t;

  function automatic logic is_mdu_funct(input int unsigned f);
    return (f >= F_MULT) && (f <= F_DIVU);
  endfunction

endpackage

// File: rtl/alu_mdu_ctrl_if.sv
// Control-FSM <-> ALU-control/MDU bundle; master is the control FSM side.
interface alu_mdu_ctrl_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ALUCTL_W = 4,
  parameter int unsigned FUNCT_W  = 6
);
  logic [2:0]          aluop;
  logic [FUNCT_W-1:0]  func;
  logic                md_start;
  logic [WIDTH-1:0]    rs_val;
  logic [WIDTH-1:0]    rt_val;
  logic [ALUCTL_W-1:0] aluctl;
  logic                illegal;
  logic [1:0]          hilo_rd;
  logic                md_stall;
  logic                md_busy;
  logic                md_done;
  logic [WIDTH-1:0]    hi;
  logic [WIDTH-1:0]    lo;

  modport master (
    output aluop, func, md_start, rs_val, rt_val,
    input  aluctl, illegal, hilo_rd, md_stall, md_busy, md_done, hi, lo
  );

  modport slave (
    input  aluop, func, md_start, rs_val, rt_val,
    output aluctl, illegal, hilo_rd, md_stall, md_busy, md_done, hi, lo
  );
endinterface

// File: rtl/md_iter.sv
// Iterative unsigned datapath: shift-add multiplier / restoring divider sharing
// one 2*WIDTH accumulator ({hi_part, lo_part}).
module md_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc
);
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   b_r;
  logic               div_r;
  logic [WIDTH-1:0]   hi_part;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx;

  assign hi_part = acc_r[2*WIDTH-1:WIDTH];
  assign add_sum = {1'b0, hi_part} + (acc_r[0] ? {1'b0, b_r} : '0);
  // rem_sh < 2*divisor, so the post-subtract remainder always fits WIDTH bits
  assign rem_sh  = {hi_part, acc_r[WIDTH-1]};
  assign ge      = rem_sh >= {1'b0, b_r};
  assign rem_nx  = ge ? WIDTH'(rem_sh - {1'b0, b_r}) : rem_sh[WIDTH-1:0];
  assign acc     = acc_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= '0;
      b_r   <= '0;
      div_r <= 1'b0;
    end else if (load) begin
      acc_r <= {{WIDTH{1'b0}}, a};
      b_r   <= b;
      div_r <= is_div;
    end else if (step) begin
      if (div_r) acc_r <= {rem_nx, acc_r[WIDTH-2:0], ge};
      else       acc_r <= {add_sum, acc_r[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/alu_mdu_ctrl.sv
// ALU control decode plus iterative mult/div unit owning HI/LO.
// Build option: define MTHILO_EN to enable mthi/mtlo (funct 17/19).
module alu_mdu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ALUCTL_W = 4,
  parameter int unsigned FUNCT_W  = 6
) (
  input logic           clk,
  input logic           reset,
  alu_mdu_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  aluop_t             op;
  logic [FUNCT_W-1:0] fn;
  int unsigned        f;
  logic [3:0]         aluctl_c;
  logic               illegal_c;
  logic               rtype, mfhi, mflo, mdu_op, mt_op, busy, issue;
  logic               is_div_op, is_signed, div0;
  logic [WIDTH-1:0]   mag_a, mag_b;

  md_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic               div_r, neg_res, neg_rem, dz, done_r;
  logic [WIDTH-1:0]   a_raw, hi_r, lo_r;
  logic [2*WIDTH-1:0] acc, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op    = aluop_t'(bus.aluop);
  assign fn    = bus.func;
  assign f     = 32'(fn);
  assign rtype = (op == AOP_RTYPE);

  always_comb begin
    aluctl_c  = AC_BAD;
    illegal_c = 1'b0;
    case (op)
      AOP_ADD: aluctl_c = AC_ADD;
      AOP_SUB: aluctl_c = AC_SUB;
      AOP_AND: aluctl_c = AC_AND;
      AOP_OR:  aluctl_c = AC_OR;
      AOP_SLT: aluctl_c = AC_SLT;
      AOP_XOR: aluctl_c = AC_XOR;
      AOP_LUI: aluctl_c = AC_LUI;
      AOP_RTYPE: begin
        case (f)
          F_ADD, F_ADDU: aluctl_c = AC_ADD;
          F_SUB, F_SUBU: aluctl_c = AC_SUB;
          F_AND:         aluctl_c = AC_AND;
          F_OR:          aluctl_c = AC_OR;
          F_XOR:         aluctl_c = AC_XOR;
          F_NOR:         aluctl_c = AC_NOR;
          F_SLT:         aluctl_c = AC_SLT;
          F_SLTU:        aluctl_c = AC_SLTU;
          F_MFHI, F_MFLO, F_MULT, F_MULTU, F_DIV, F_DIVU: aluctl_c = AC_ADD;
`ifdef MTHILO_EN
          F_MTHI, F_MTLO: aluctl_c = AC_ADD;
`endif
          default:       illegal_c = 1'b1;
        endcase
      end
      default: aluctl_c = AC_BAD;
    endcase
  end

  assign mfhi   = rtype && (f == F_MFHI);
  assign mflo   = rtype && (f == F_MFLO);
  assign mdu_op = rtype && is_mdu_funct(f);
`ifdef MTHILO_EN
  assign mt_op  = rtype && ((f == F_MTHI) || (f == F_MTLO));
`else
  assign mt_op  = 1'b0;
`endif
  assign busy   = (state != MD_IDLE);
  assign issue  = bus.md_start && mdu_op && !busy;

  // funct 24..27: bit1 selects divide, bit0 selects unsigned
  assign is_div_op = fn[1];
  assign is_signed = !fn[0];
  assign div0      = is_div_op && (bus.rt_val == '0);
  assign mag_a     = (is_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
  assign mag_b     = (is_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;

  md_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (issue),
    .step   (state == MD_RUN),
    .is_div (is_div_op),
    .a      (mag_a),
    .b      (mag_b),
    .acc    (acc)
  );

  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      div_r   <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      a_raw   <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (issue) begin
            div_r   <= is_div_op;
            neg_res <= is_signed && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
            neg_rem <= is_signed && bus.rs_val[WIDTH-1];
            dz      <= div0;
            a_raw   <= bus.rs_val;
            cnt     <= '0;
            state   <= div0 ? MD_SIGN : MD_RUN;
          end
`ifdef MTHILO_EN
          else if (bus.md_start && mt_op) begin
            if (f == F_MTHI) hi_r <= bus.rs_val;
            else             lo_r <= bus.rs_val;
          end
`endif
        end
        MD_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= MD_SIGN;
        end
        MD_SIGN: begin
          if (dz) begin
            hi_r <= a_raw;
            lo_r <= '1;
          end else if (div_r) begin
            hi_r <= rem_fix;
            lo_r <= quo_fix;
          end else begin
            {hi_r, lo_r} <= prod_fix;
          end
          done_r <= 1'b1;
          state  <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign bus.aluctl   = ALUCTL_W'(aluctl_c);
  assign bus.illegal  = illegal_c;
  assign bus.hilo_rd  = {mfhi, mflo};
  assign bus.md_stall = busy && ((bus.md_start && mdu_op) || mfhi || mflo || mt_op);
  assign bus.md_busy  = busy;
  assign bus.md_done  = done_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
endmodule
